// File: rtl/sp_ram_banked_if.sv
// ============================================================================
// Module   : sp_ram_banked_if
// Purpose  : picosoc native valid/ready bus carried into the banked RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sp_ram_banked_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        addr_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, addr_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, addr_err
  );
endinterface

`default_nettype wire

// File: rtl/sp_ram_banked.sv
// ============================================================================
// Module   : sp_ram_banked
// Purpose  : NUM_BANKS x 256x64 SRAM macros behind the picosoc bus, with
//            byte masking, out-of-range detection and optional zero-fill.
// Revision : 1.0
// ============================================================================
`default_nettype none

// Behavioural model of the single-port 64-bit macro; replaced by the library
// cell in implementation. BIST inputs take over the array when A_BIST_EN=1.
module RM_IHPSG13_1P_256x64_c2_bm_bist #(
  parameter int ADDR_W = 8
) (
  input  logic              A_CLK,
  input  logic              A_DLY,
  input  logic              A_MEN,
  input  logic              A_WEN,
  input  logic              A_REN,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [63:0]       A_DIN,
  input  logic [63:0]       A_BM,
  output logic [63:0]       A_DOUT,
  input  logic              A_BIST_CLK,
  input  logic              A_BIST_EN,
  input  logic              A_BIST_MEN,
  input  logic              A_BIST_WEN,
  input  logic              A_BIST_REN,
  input  logic [ADDR_W-1:0] A_BIST_ADDR,
  input  logic [63:0]       A_BIST_DIN,
  input  logic [63:0]       A_BIST_BM
);
  logic [63:0]       mem [0:(1<<ADDR_W)-1];
  logic              men;
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       din;
  logic [63:0]       bm;
  logic              model_unused;

  assign model_unused = A_DLY ^ A_BIST_CLK;
  assign men  = A_BIST_EN ? A_BIST_MEN  : A_MEN;
  assign wen  = A_BIST_EN ? A_BIST_WEN  : A_WEN;
  assign ren  = A_BIST_EN ? A_BIST_REN  : A_REN;
  assign addr = A_BIST_EN ? A_BIST_ADDR : A_ADDR;
  assign din  = A_BIST_EN ? A_BIST_DIN  : A_DIN;
  assign bm   = A_BIST_EN ? A_BIST_BM   : A_BM;

  always_ff @(posedge A_CLK) begin
    if (men) begin
      if (wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
      if (ren) A_DOUT <= mem[addr];
    end
  end
endmodule

module sp_ram_banked #(
  parameter int NUM_BANKS      = 2,
  parameter int ROW_ADDR_W     = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int SRAM_DLY       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_banked_if.slave        bus,
  output logic                  init_done
);
  localparam int                    BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [29:0]           WORD_LIMIT   = 30'(NUM_BANKS) << (ROW_ADDR_W + 1);
  localparam logic [ROW_ADDR_W-1:0] LAST_ROW     = {ROW_ADDR_W{1'b1}};
  localparam logic                  SRAM_DLY_BIT = 1'(SRAM_DLY);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ROW_ADDR_W-1:0]  clr_row;
  logic [BANK_W-1:0]      resp_bank;
  logic                   resp_half;
  logic                   resp_read;
  logic                   resp_err;

  logic [29:0]            word_idx;
  logic                   in_range;
  logic [BANK_W-1:0]      req_bank;
  logic [ROW_ADDR_W-1:0]  req_row;
  logic                   req_half;
  logic                   req_write;
  logic [31:0]            byte_mask;
  logic [63:0]            req_bm;
  logic                   addr_unused;

  logic [NUM_BANKS-1:0]   bank_men;
  logic                   mac_wen;
  logic                   mac_ren;
  logic [ROW_ADDR_W-1:0]  mac_addr;
  logic [63:0]            mac_din;
  logic [63:0]            mac_bm;
  logic [63:0]            dout [NUM_BANKS];
  logic [63:0]            dout_sel;

  // Address decode: two words per macro row, banks stacked above the rows.
  assign word_idx    = bus.mem_addr[31:2];
  assign in_range    = word_idx < WORD_LIMIT;
  assign req_row     = bus.mem_addr[ROW_ADDR_W+2:3];
  assign req_half    = bus.mem_addr[2];
  assign req_write   = |bus.mem_wstrb;
  assign addr_unused = ^bus.mem_addr[1:0];
  assign byte_mask   = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                        {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
  assign req_bm      = req_half ? {byte_mask, 32'h0} : {32'h0, byte_mask};

  generate
    if (NUM_BANKS > 1) begin : g_bank_multi
      assign req_bank = word_idx[ROW_ADDR_W+1 +: BANK_W];
    end else begin : g_bank_single
      assign req_bank = '0;
    end
  endgenerate

  assign dout_sel = dout[resp_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      clr_row   <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
      resp_bank <= '0;
      resp_half <= 1'b0;
      resp_read <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        clr_row <= clr_row + ROW_ADDR_W'(1);
        if (clr_row == LAST_ROW) init_done <= 1'b1;
      end
      if (state == ST_IDLE && bus.mem_valid) begin
        resp_bank <= req_bank;
        resp_half <= req_half;
        resp_read <= in_range && !req_write;
        resp_err  <= !in_range;
      end
    end
  end

  always_comb begin
    state_next    = state;
    bank_men      = '0;
    mac_wen       = 1'b0;
    mac_ren       = 1'b0;
    mac_addr      = req_row;
    mac_din       = {bus.mem_wdata, bus.mem_wdata};
    mac_bm        = req_bm;
    bus.mem_ready = 1'b0;
    bus.addr_err  = 1'b0;
    bus.mem_rdata = 32'h0;
    case (state)
      ST_INIT: begin
        bank_men = '1;
        mac_wen  = 1'b1;
        mac_addr = clr_row;
        mac_din  = '0;
        mac_bm   = '1;
        if (clr_row == LAST_ROW) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.mem_valid) begin
          state_next = ST_RESP;
          if (in_range) begin
            bank_men[req_bank] = 1'b1;
            mac_wen            = req_write;
            mac_ren            = !req_write;
          end
        end
      end
      ST_RESP: begin
        bus.mem_ready = 1'b1;
        bus.addr_err  = resp_err;
        if (resp_read) bus.mem_rdata = resp_half ? dout_sel[63:32] : dout_sel[31:0];
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // No macro may be touched while reset is held, whatever state holds.
    if (rst) bank_men = '0;
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      RM_IHPSG13_1P_256x64_c2_bm_bist #(
        .ADDR_W (ROW_ADDR_W)
      ) u_macro (
        .A_CLK       (clk),
        .A_DLY       (SRAM_DLY_BIT),
        .A_MEN       (bank_men[b]),
        .A_WEN       (mac_wen),
        .A_REN       (mac_ren),
        .A_ADDR      (mac_addr),
        .A_DIN       (mac_din),
        .A_BM        (mac_bm),
        .A_DOUT      (dout[b]),
        .A_BIST_CLK  (1'b0),
        .A_BIST_EN   (1'b0),
        .A_BIST_MEN  (1'b0),
        .A_BIST_WEN  (1'b0),
        .A_BIST_REN  (1'b0),
        .A_BIST_ADDR ('0),
        .A_BIST_DIN  (64'h0),
        .A_BIST_BM   (64'h0)
      );
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_sp_ram_banked.sv
// ============================================================================
// Module   : tb_sp_ram_banked
// Purpose  : Scoreboard bench for sp_ram_banked (2 banks, zero-fill on reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sp_ram_banked;
  localparam int NUM_BANKS  = 2;
  localparam int ROW_ADDR_W = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [31:0] model [int];

  sp_ram_banked_if bus();

  sp_ram_banked #(
    .NUM_BANKS      (NUM_BANKS),
    .ROW_ADDR_W     (ROW_ADDR_W),
    .CLEAR_ON_RESET (1),
    .SRAM_DLY       (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input int w);
    return model.exists(w) ? model[w] : 32'h0;
  endfunction

  function automatic void mwrite(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = mread(w);
    for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
    model[w] = cur;
  endfunction

  task automatic bus_idle();
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
  endtask

  // One complete transaction: expectation queued at issue, checked at mem_ready.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t                 e;
    logic [NUM_BANKS-1:0] exp_men;
    bit                   got;
    exp_q.push_back('{err: exp_err, rdata: exp_rd});
    exp_men = '0;
    if ((a >> 2) < (NUM_BANKS << (ROW_ADDR_W + 1))) exp_men[a >> (ROW_ADDR_W + 3)] = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    #1;
    total++;
    if (dut.bank_men !== exp_men) begin
      bad++;
      $display("FAIL %s men: got %b want %b", name, dut.bank_men, exp_men);
    end
    @(negedge clk);
    got = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (bus.mem_ready === 1'b1) begin
        got = 1'b1;
        total++;
        if (c != 1) begin
          bad++;
          $display("FAIL %s latency: got %0d want 1 cycle", name, c);
        end
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no mem_ready want mem_ready", name);
      void'(exp_q.pop_front());
      bus_idle();
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (bus.mem_rdata !== e.rdata) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", name, bus.mem_rdata, e.rdata);
    end
    total++;
    if (bus.addr_err !== e.err) begin
      bad++;
      $display("FAIL %s addr_err: got %b want %b", name, bus.addr_err, e.err);
    end
    bus_idle();
    @(negedge clk);
    total++;
    if (bus.mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_pulse: got %b want 0", name, bus.mem_ready);
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (init_done !== 1'b1 && n < 400);
  endtask

  task automatic test_reset();
    int n;
    int ready_seen;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst init_done: got %b want 0", init_done); end
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rst ready: got %b want 0", bus.mem_ready); end
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL rst addr_err: got %b want 0", bus.addr_err); end
    total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL rst rdata: got %h want 0", bus.mem_rdata); end
    total++; if (dut.bank_men !== '0) begin bad++; $display("FAIL rst men: got %b want 0", dut.bank_men); end
    rst = 1'b0;
    // A request held during zero-fill must be ignored entirely.
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_wstrb = 4'hF;
    n = 0;
    ready_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_ready === 1'b1) ready_seen++;
      if (n == 200) bus_idle();
    end while (init_done !== 1'b1 && n < 400);
    total++; if (n != 256) begin bad++; $display("FAIL init_cycles: got %0d want 256", n); end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL init_ready: got %0d want 0", ready_seen); end
  endtask

  task automatic test_clear();
    access(32'h000, 32'h0, 4'h0, 32'h0, 1'b0, "clr_000");
    access(32'hFFC, 32'h0, 4'h0, 32'h0, 1'b0, "clr_ffc");
  endtask

  task automatic test_halves();
    access(32'h004, 32'h11223344, 4'hF, 32'h0, 1'b0, "wr_hi");
    access(32'h000, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0, "wr_lo");
    access(32'h004, 32'h0, 4'h0, 32'h11223344, 1'b0, "rd_hi");
    access(32'h000, 32'h0, 4'h0, 32'hAABBCCDD, 1'b0, "rd_lo");
  endtask

  task automatic test_byte_mask();
    access(32'h010, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, "bm_fill");
    access(32'h010, 32'h00000000, 4'b0101, 32'h0, 1'b0, "bm_wr");
    access(32'h010, 32'h0, 4'h0, 32'hFF00FF00, 1'b0, "bm_rd");
    access(32'h014, 32'h0, 4'h0, 32'h0, 1'b0, "bm_other_half");
    access(32'h004, 32'h0, 4'h0, 32'h11223344, 1'b0, "bm_other_row");
  endtask

  task automatic test_banks();
    access(32'h800, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "bank1_wr");
    access(32'h000, 32'h01020304, 4'hF, 32'h0, 1'b0, "bank0_wr");
    access(32'h800, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "bank1_rd");
    access(32'h000, 32'h0, 4'h0, 32'h01020304, 1'b0, "bank0_rd");
  endtask

  task automatic test_addr_err();
    access(32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1, "oor_wr");
    access(32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, "oor_rd");
    access(32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1, "oor_top");
    access(32'h000, 32'h0, 4'h0, 32'h01020304, 1'b0, "oor_no_alias");
  endtask

  task automatic test_rst_mid_init();
    int n;
    access(32'h000, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, "pre_000");
    access(32'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, "pre_ffc");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_init init_done: got %b want 0", init_done); end
    rst = 1'b0;
    wait_init(n);
    total++; if (n != 256) begin bad++; $display("FAIL mid_init cycles: got %0d want 256", n); end
    access(32'h000, 32'h0, 4'h0, 32'h0, 1'b0, "refill_000");
    access(32'hFFC, 32'h0, 4'h0, 32'h0, 1'b0, "refill_ffc");
    access(32'h800, 32'h0, 4'h0, 32'h0, 1'b0, "refill_800");
  endtask

  task automatic test_rst_mid_access();
    int n;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h008;
    bus.mem_wdata = 32'h77777777;
    bus.mem_wstrb = 4'hF;
    #1 rst = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL mid_acc ready: got %b want 0", bus.mem_ready); end
    bus_idle();
    rst = 1'b0;
    wait_init(n);
    total++; if (n != 256) begin bad++; $display("FAIL mid_acc cycles: got %0d want 256", n); end
    access(32'h008, 32'h0, 4'h0, 32'h0, 1'b0, "mid_acc_rd");
  endtask

  task automatic test_back_to_back();
    int          w;
    logic [31:0] d;
    logic [3:0]  s;
    model.delete();
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 15) + ($urandom_range(0, 1) << (ROW_ADDR_W + 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        mwrite(w, d, s);
        access(32'(w) << 2, d, s, 32'h0, 1'b0, "rnd_wr");
      end else begin
        access(32'(w) << 2, 32'h0, 4'h0, mread(w), 1'b0, "rnd_rd");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_idle();
    test_reset();
    test_clear();
    test_halves();
    test_byte_mask();
    test_banks();
    test_addr_err();
    test_rst_mid_init();
    test_rst_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
